// File: rtl/ddr_out_reg.sv
// Single-bit DDR output register: r0 is shown while clk_i is high, r1 while low.
// Optional input alignment captures both bits on one edge and replays one via a hold.
module ddr_out_reg #(
  parameter logic  INIT          = 1'b0,
  parameter string DDR_ALIGNMENT = "NONE"
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic ce_i,
  input  logic set_i,
  input  logic d0_i,
  input  logic d1_i,
  output logic q_o
);

  localparam bit ALIGN_NONE = (DDR_ALIGNMENT == "NONE");
  localparam bit ALIGN_C0   = (DDR_ALIGNMENT == "C0");
  localparam bit ALIGN_C1   = (DDR_ALIGNMENT == "C1");

  generate
    if (!(ALIGN_NONE || ALIGN_C0 || ALIGN_C1)) begin : g_bad_alignment
      $error("ddr_out_reg: DDR_ALIGNMENT must be NONE, C0 or C1");
    end
  endgenerate

  // Power-up values come from the configuration image, not from reset.
  logic r0_q = INIT;
  logic h1_q = INIT;
  logic r1_q = INIT;
  logic h0_q = INIT;

  logic r0_d;
  logic h1_d;
  logic r1_d;
  logic h0_d;

  // C0 (rising-edge) domain: output register r0 and the d1 hold for "C0".
  always_comb begin
    r0_d = r0_q;
    h1_d = h1_q;
    if (!rst_n_i) begin
      r0_d = 1'b0;
      h1_d = 1'b0;
    end else if (set_i) begin
      r0_d = 1'b1;
      h1_d = 1'b1;
    end else if (ce_i) begin
      if (ALIGN_C1) begin
        r0_d = h0_q;
      end else begin
        r0_d = d0_i;
        if (ALIGN_C0) h1_d = d1_i;
      end
    end
  end

  // C1 (falling-edge) domain: output register r1 and the d0 hold for "C1".
  always_comb begin
    r1_d = r1_q;
    h0_d = h0_q;
    if (!rst_n_i) begin
      r1_d = 1'b0;
      h0_d = 1'b0;
    end else if (set_i) begin
      r1_d = 1'b1;
      h0_d = 1'b1;
    end else if (ce_i) begin
      if (ALIGN_C0) begin
        r1_d = h1_q;
      end else begin
        r1_d = d1_i;
        if (ALIGN_C1) h0_d = d0_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    r0_q <= r0_d;
    h1_q <= h1_d;
  end

  always_ff @(negedge clk_i) begin
    r1_q <= r1_d;
    h0_q <= h0_d;
  end

  // Phase select only; maps onto the vendor DDR output primitive.
  assign q_o = clk_i ? r0_q : r1_q;

endmodule

// File: tb/tb_ddr_out_reg.sv
// Directed bench for ddr_out_reg: three alignment modes plus an INIT=1 instance,
// expected pin values queued per half-cycle and checked after each clock edge.
module tb_ddr_out_reg;

  logic clk = 1'b0;
  logic rst_n;
  logic ce;
  logic set;
  logic d0;
  logic d1;
  logic q_none;
  logic q_c0;
  logic q_c1;
  logic q_i1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [3:0] exp;   // {init1, c1, c0, none}
  } exp_t;

  exp_t sb[$];
  string names[4] = '{"none", "c0", "c1", "init1"};

  always #5 clk = ~clk;

  ddr_out_reg #(.INIT(1'b0), .DDR_ALIGNMENT("NONE")) u_none (
    .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .set_i(set),
    .d0_i(d0), .d1_i(d1), .q_o(q_none));

  ddr_out_reg #(.INIT(1'b0), .DDR_ALIGNMENT("C0")) u_c0 (
    .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .set_i(set),
    .d0_i(d0), .d1_i(d1), .q_o(q_c0));

  ddr_out_reg #(.INIT(1'b0), .DDR_ALIGNMENT("C1")) u_c1 (
    .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .set_i(set),
    .d0_i(d0), .d1_i(d1), .q_o(q_c1));

  ddr_out_reg #(.INIT(1'b1), .DDR_ALIGNMENT("NONE")) u_i1 (
    .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .set_i(set),
    .d0_i(d0), .d1_i(d1), .q_o(q_i1));

  task automatic check_out();
    exp_t       e;
    logic [3:0] obs;
    obs = {q_i1, q_c1, q_c0, q_none};
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL scoreboard_empty: got size=%0d expected nonzero", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int i = 0; i < 4; i++) begin
        total++;
        assert (obs[i] === e.exp[i]) else begin
          bad++;
          $error("FAIL %s inst=%s t=%0t q=%b expected=%b", e.tag, names[i], $time, obs[i], e.exp[i]);
        end
      end
    end
  endtask

  // One half-cycle: drive inputs, queue the pin values due after the next edge, then check.
  task automatic hp(input string tag, input logic id0, input logic id1, input logic ice,
                    input logic irst_n, input logic iset,
                    input logic e_none, input logic e_c0, input logic e_c1);
    exp_t e;
    d0    = id0;
    d1    = id1;
    ce    = ice;
    rst_n = irst_n;
    set   = iset;
    e.tag = tag;
    e.exp = {e_none, e_c1, e_c0, e_none};
    sb.push_back(e);
    @(clk);
    #2;
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e0;
    rst_n = 1'b1;
    set   = 1'b0;
    ce    = 1'b1;
    d0    = 1'b0;
    d1    = 1'b0;

    // Before any edge the pin shows INIT.
    e0.tag = "init_pre_edge";
    e0.exp = 4'b1000;
    sb.push_back(e0);
    #1;
    check_out();

    hp("init_first_rise", 0, 0, 1, 1, 0, 0, 0, 0);
    hp("init_first_fall", 0, 0, 1, 1, 0, 0, 0, 0);
    hp("rst_rise",        0, 0, 1, 0, 0, 0, 0, 0);
    hp("rst_fall",        0, 0, 1, 0, 0, 0, 0, 0);

    // Clock forwarding; C1 shows the cleared hold on the first rise.
    for (int i = 0; i < 20; i++) begin
      hp("fwd_hi", 1, 0, 1, 1, 0, 1, 1, (i == 0) ? 1'b0 : 1'b1);
      hp("fwd_lo", 1, 0, 1, 1, 0, 0, 0, 0);
    end

    hp("ddr_11_hi", 1, 1, 1, 1, 0, 1, 1, 1);
    hp("ddr_11_lo", 1, 1, 1, 1, 0, 1, 1, 1);
    hp("ddr_01_hi", 0, 1, 1, 1, 0, 0, 0, 1);
    hp("ddr_01_lo", 0, 1, 1, 1, 0, 1, 1, 1);
    hp("ddr_10_hi", 1, 0, 1, 1, 0, 1, 1, 0);
    hp("ddr_10_lo", 1, 0, 1, 1, 0, 0, 0, 0);
    hp("ddr_00_hi", 0, 0, 1, 1, 0, 0, 0, 1);
    hp("ddr_00_lo", 0, 0, 1, 1, 0, 0, 0, 0);

    // Data changes between the edges of one cycle.
    hp("align_1", 1, 0, 1, 1, 0, 1, 1, 0);
    hp("align_2", 0, 1, 1, 1, 0, 1, 0, 1);
    hp("align_3", 0, 1, 1, 1, 0, 0, 0, 0);
    hp("align_4", 1, 0, 1, 1, 0, 0, 1, 0);
    hp("align_5", 0, 0, 1, 1, 0, 0, 0, 1);
    hp("align_6", 0, 0, 1, 1, 0, 0, 0, 0);
    hp("align_7", 0, 0, 1, 1, 0, 0, 0, 0);
    hp("align_8", 0, 0, 1, 1, 0, 0, 0, 0);

    hp("srst_run_hi",  1, 1, 1, 1, 0, 1, 1, 0);
    hp("srst_run_lo",  1, 1, 1, 1, 0, 1, 1, 1);
    hp("srst_a_hi",    1, 1, 1, 0, 0, 0, 0, 0);
    hp("srst_a_lo",    1, 1, 1, 0, 0, 0, 0, 0);
    hp("srst_set_hi",  1, 1, 1, 0, 1, 0, 0, 0);
    hp("srst_set_lo",  1, 1, 1, 0, 1, 0, 0, 0);
    hp("srst_rel_hi",  1, 1, 1, 1, 0, 1, 1, 0);
    hp("srst_rel_lo",  1, 1, 1, 1, 0, 1, 1, 1);
    hp("srst_run2_hi", 1, 1, 1, 1, 0, 1, 1, 1);
    hp("srst_run2_lo", 1, 1, 1, 1, 0, 1, 1, 1);

    hp("set_hi",       0, 0, 1, 1, 1, 1, 1, 1);
    hp("set_lo",       0, 0, 1, 1, 1, 1, 1, 1);
    hp("post_set_hi",  0, 0, 1, 1, 0, 0, 0, 1);
    hp("post_set_lo",  1, 1, 1, 1, 0, 1, 0, 1);
    hp("ce0_a_hi",     1, 1, 0, 1, 0, 0, 0, 1);
    hp("ce0_a_lo",     0, 0, 0, 1, 0, 1, 0, 1);
    hp("ce0_b_hi",     1, 0, 0, 1, 0, 0, 0, 1);
    hp("ce0_b_lo",     0, 1, 0, 1, 0, 1, 0, 1);
    hp("hold_cap_hi",  0, 1, 1, 1, 0, 0, 0, 1);
    hp("hold_keep_lo", 0, 0, 0, 1, 0, 1, 0, 1);
    hp("hold_keep_hi", 0, 0, 0, 1, 0, 0, 0, 1);
    hp("hold_emit_lo", 0, 0, 1, 1, 0, 0, 1, 0);
    hp("rst_ce0_hi",   1, 1, 0, 0, 0, 0, 0, 0);
    hp("rst_ce0_lo",   1, 1, 0, 0, 0, 0, 0, 0);
    hp("recover_hi",   1, 0, 1, 1, 0, 1, 1, 0);
    hp("recover_lo",   1, 0, 1, 1, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
